acs_path_metric: RTL and testbench

- Add-compare-select (ACS) and path-metric stage of the Viterbi decoder, directly downstream of branch_metric.
- Per received symbol, it walks all trellis states, one state per cycle.
  - Drives the current symbol and the two expected symbols to branch_metric.
  - Takes bm0/bm1 back in the same cycle.
  - Updates double-buffered path metrics.
- Emits one vector of survivor decision bits per symbol to the traceback stage, with the best state and its metric.

---
 rtl/acs_path_metric.sv | 120 ++++++++++++
 tb/tb_acs_path_metric.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/acs_path_metric.sv
// acs_path_metric: Viterbi add-compare-select stage, one trellis state per cycle
// over double-buffered path metrics normalized by the previous symbol's minimum.
module acs_path_metric #(
    parameter int K       = 3,
    parameter int G0      = 7,
    parameter int G1      = 5,
    parameter int Wb      = 2,
    parameter int Wm      = 6,
    parameter int INIT_PM = 16,
    localparam int NS     = 1 << (K - 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    sym_in,
    input  logic          sym_valid,
    output logic          sym_ready,
    output logic [1:0]    bm_rx_sym,
    output logic [1:0]    exp_sym0,
    output logic [1:0]    exp_sym1,
    input  logic [Wb-1:0] bm0,
    input  logic [Wb-1:0] bm1,
    output logic [NS-1:0] dec_bits,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [K-2:0]  best_state,
    output logic [Wm-1:0] best_pm
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [K-1:0] g0_mask = K'(G0);
    localparam logic [K-1:0] g1_mask = K'(G1);

    state_t        state, nxt;
    logic          bank;
    logic [Wm-1:0] pm [2][NS];
    logic [Wm-1:0] min_prev, run_min, cur_min, c0, c1, sel;
    logic [K-2:0]  j, run_idx, cur_idx, p0, p1;
    logic [Wm:0]   s0, s1;
    logic          dec, last, better;

    function automatic logic [1:0] exp_of(input logic u, input logic [K-2:0] p);
        logic [K-1:0] r;
        r = {u, p};
        return {^(r & g0_mask), ^(r & g1_mask)};
    endfunction

    assign p0       = {1'b0, j[K-2:1]};
    assign p1       = {1'b1, j[K-2:1]};
    assign exp_sym0 = exp_of(j[0], p0);
    assign exp_sym1 = exp_of(j[0], p1);
    assign last     = &j;

    // The extra top bit of s0/s1 flags overflow; subtraction cannot underflow.
    always_comb begin
        s0      = {1'b0, pm[bank][p0]} - {1'b0, min_prev} + {{(Wm + 1 - Wb){1'b0}}, bm0};
        s1      = {1'b0, pm[bank][p1]} - {1'b0, min_prev} + {{(Wm + 1 - Wb){1'b0}}, bm1};
        c0      = s0[Wm] ? '1 : s0[Wm-1:0];
        c1      = s1[Wm] ? '1 : s1[Wm-1:0];
        dec     = c1 < c0;
        sel     = dec ? c1 : c0;
        better  = (j == '0) || (sel < run_min);
        cur_min = better ? sel : run_min;
        cur_idx = better ? j : run_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state == IDLE ? (sym_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (dec_ready ? IDLE : DONE);
    end

    always_comb begin
        sym_ready = state == IDLE;
        dec_valid = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                pm[0][i] <= (i == 0) ? '0 : Wm'(INIT_PM);
                pm[1][i] <= '0;
            end
            bank       <= 1'b0;
            min_prev   <= '0;
            run_min    <= '0;
            run_idx    <= '0;
            j          <= '0;
            dec_bits   <= '0;
            best_state <= '0;
            best_pm    <= '0;
            bm_rx_sym  <= '0;
        end else begin
            if (state == IDLE && sym_valid) begin
                bm_rx_sym <= sym_in;
                j         <= '0;
            end
            if (state == RUN) begin
                pm[~bank][j] <= sel;
                dec_bits[j]  <= dec;
                run_min      <= cur_min;
                run_idx      <= cur_idx;
                j            <= j + 1'b1;
                if (last) begin
                    bank       <= ~bank;
                    min_prev   <= cur_min;
                    best_pm    <= cur_min;
                    best_state <= cur_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_acs_path_metric.sv
// tb_acs_path_metric: directed scoreboard bench for the K=3 ACS stage, with a
// closed-form (7,5) trellis model for the long symbol run.
module tb_acs_path_metric;
    typedef struct {
        logic [3:0] dec;
        logic [1:0] best;
        logic [5:0] bpm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sym_in = '0;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [1:0] bm_rx_sym, exp_sym0, exp_sym1;
    logic [1:0] bm0, bm1;
    logic [3:0] dec_bits;
    logic       dec_valid;
    logic       dec_ready = 1'b1;
    logic [1:0] best_state;
    logic [5:0] best_pm;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   mpm[4];
    int   mmin;

    always #5 clk = ~clk;

    function automatic logic [1:0] hd(input logic [1:0] a, input logic [1:0] b);
        return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
    endfunction

    assign bm0 = hd(bm_rx_sym, exp_sym0);
    assign bm1 = hd(bm_rx_sym, exp_sym1);

    acs_path_metric dut (
        .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .bm_rx_sym(bm_rx_sym), .exp_sym0(exp_sym0),
        .exp_sym1(exp_sym1), .bm0(bm0), .bm1(bm1), .dec_bits(dec_bits),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .best_state(best_state),
        .best_pm(best_pm)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [1:0] b, input logic [5:0] p);
        exp_t e;
        e.dec = d;
        e.best = b;
        e.bpm = p;
        sb.push_back(e);
    endtask

    // Encoder register {u, p1, p0} with G0=111, G1=101.
    task automatic model_reset();
        mpm = '{0, 16, 16, 16};
        mmin = 0;
    endtask

    task automatic model_step(input logic [1:0] s);
        int nw[4];
        int c[2];
        int bst;
        logic [3:0] d;
        for (int ns = 0; ns < 4; ns++) begin
            for (int b = 0; b < 2; b++) begin
                int p;
                logic u, q1, q0;
                logic [1:0] e;
                p = b * 2 + ns / 2;
                u = ns[0];
                q1 = p[1];
                q0 = p[0];
                e = {u ^ q1 ^ q0, u ^ q0};
                c[b] = mpm[p] - mmin + int'(hd(s, e));
                if (c[b] > 63) c[b] = 63;
            end
            d[ns] = c[1] < c[0];
            nw[ns] = d[ns] ? c[1] : c[0];
        end
        bst = 0;
        for (int i = 1; i < 4; i++) if (nw[i] < nw[bst]) bst = i;
        mmin = nw[bst];
        mpm = nw;
        push(d, 2'(bst), 6'(mmin));
    endtask

    task automatic send(input logic [1:0] s, output int waited);
        waited = 0;
        sym_in = s;
        sym_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sym_ready) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1 sym_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        check("drain_empty", sb.size(), 0);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dec_bits", int'(dec_bits), int'(e.dec));
                check("best_state", int'(best_state), int'(e.best));
                check("best_pm", int'(best_pm), int'(e.bpm));
            end
        end
    end

    initial begin
        int w;
        logic [11:0] snap;
        logic [1:0] e0 [4];
        logic [1:0] e1 [4];
        e0 = '{2'b00, 2'b11, 2'b11, 2'b00};
        e1 = '{2'b10, 2'b01, 2'b01, 2'b10};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_sym_ready", int'(sym_ready), 1);
        check("rst_dec_valid", int'(dec_valid), 0);
        check("rst_dec_bits", int'(dec_bits), 0);
        check("rst_best", int'({best_state, best_pm}), 0);
        check("rst_bm_rx_sym", int'(bm_rx_sym), 0);
        @(posedge clk);
        #1;

        // Two 00 symbols from reset, then 11 from reset with expected-symbol and latency checks.
        push(4'b0100, 2'd0, 6'd0);
        send(2'b00, w);
        push(4'b0000, 2'd0, 6'd0);
        send(2'b00, w);
        drain();
        do_reset();
        push(4'b1000, 2'd1, 6'd0);
        send(2'b11, w);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("exp_sym0", int'(exp_sym0), int'(e0[k]));
            check("exp_sym1", int'(exp_sym1), int'(e1[k]));
            check("run_not_ready", int'(sym_ready), 0);
            if (k == 3) check("lat_early", int'(dec_valid), 0);
        end
        @(negedge clk);
        check("lat_valid", int'(dec_valid), 1);
        drain();

        // Backpressure in DONE with a pending symbol upstream.
        do_reset();
        dec_ready = 1'b0;
        push(4'b0100, 2'd0, 6'd0);
        send(2'b00, w);
        for (int i = 0; i < 20 && !dec_valid; i++) @(negedge clk);
        snap = {dec_bits, best_state, best_pm};
        @(posedge clk);
        #1 sym_in = 2'b11;
        sym_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", int'({sym_ready, dec_valid, dec_bits, best_state, best_pm}),
                  int'({1'b0, 1'b1, snap}));
            check("bp_rx_sym", int'(bm_rx_sym), 0);
        end
        @(posedge clk);
        #1 dec_ready = 1'b1;
        push(4'b0000, 2'd1, 6'd0);
        send(2'b11, w);
        check("bp_accept_next_idle", w, 1);
        drain();

        // Reset during RUN at j = 2 discards the partial bank.
        do_reset();
        send(2'b11, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrun_idle", int'(sym_ready), 1);
        check("midrun_dec_valid", int'(dec_valid), 0);
        push(4'b0100, 2'd0, 6'd0);
        send(2'b00, w);
        drain();

        // Long symbol run against the trellis model.
        do_reset();
        model_reset();
        for (int i = 0; i < 500; i++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            model_step(s);
            send(s, w);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
